fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write-port arbiter that shares the single write port of the synchronous FIFO among NUM_REQ independent producers. It drives the FIFO write enable and data combinationally from the winning requester, and never issues a write while the FIFO reports full. Arbitration state (round-robin pointer, optional burst lock, write statistics) is registered. It sits directly in front of the FIFO write side, alongside the FIFO assertion monitor.

## Interface
- DATA_WIDTH, 8, FIFO word width
- NUM_REQ, 4, number of requesters (2..8)
- BURST_LEN, 4, max consecutive writes per lock; only used with FIFO_ARB_BURST_EN (1..15)
- clk  input  1  rising-edge clock
- reset_n  input  1  reset, asynchronous, active-low
- req  input  NUM_REQ  per-requester write request
- req_data  input  NUM_REQ*DATA_WIDTH  requester k data in bits [k*DATA_WIDTH +: DATA_WIDTH]
- full  input  1  FIFO full flag
- gnt  output  NUM_REQ  one-hot same-cycle acknowledge; data accepted at the clock edge while high
- Wr_enable  output  1  FIFO write enable
- data_in  output  DATA_WIDTH  FIFO write data
- owner  output  $clog2(NUM_REQ)  index of last granted requester (registered)
- busy  output  1  burst lock held (always 0 without FIFO_ARB_BURST_EN)
- wr_count  output  16  total accepted writes, saturating

## Operation
- Grant condition: full==0, reset_n==1, and an eligible req bit set. Otherwise gnt=0, Wr_enable=0, data_in=0.
- Wr_enable = |gnt; data_in = req_data slice of granted index. At most one gnt bit high.
- IDLE arbitration: winner = first k with req[k]=1, searching rr_ptr, rr_ptr+1, … modulo NUM_REQ.
- On each grant to w (unlocked mode): rr_ptr <= (w+1) mod NUM_REQ; owner <= w.
- Requester protocol: hold req and req_data stable until gnt seen high; may deassert req the cycle after gnt.
- full==1 blocks all grants; rr_ptr, owner, lock state unchanged.
- wr_count += 1 per cycle with Wr_enable=1; holds at 16'hFFFF.
- States: IDLE, LOCKED (LOCKED reachable only with FIFO_ARB_BURST_EN).

## Timing
- Grant/write path combinational: req to gnt/Wr_enable zero cycles; no added latency to FIFO.
- Registered state updates on rising clk.
- Reset (reset_n low, asynchronous): rr_ptr=0, owner=0, state IDLE, burst count 0, busy=0, wr_count=0; gnt=0, Wr_enable=0, data_in=0 forced immediately.
- Reset mid-burst: lock dropped; first grant after release goes to lowest-index requester with req set.
- full rising while requests pending: no write that cycle; grant resumes the first cycle full==0, same winner (rr_ptr unchanged).
- All req low: no state change.

## Configuration
- FIFO_ARB_BURST_EN defined: first grant to w in IDLE moves to LOCKED, cnt=1, busy=1. In LOCKED only w is eligible. Grant when req[w]=1 and full=0: cnt++. Release to IDLE (rr_ptr <= w+1) at the edge where cnt reaches BURST_LEN, or in a cycle with req[w]=0 (that cycle: no grant, one bubble). full=1 in LOCKED: stall, lock kept, cnt unchanged. BURST_LEN=1 behaves as undefined case.
- Not defined: no LOCKED state, no counter logic; rotate after every write; busy tied 0.

## Test plan
- Reset then req=4'b1111 held, full=0 -> gnt sequence 0001,0010,0100,1000,0001; wr_count=5 after 5 cycles; data_in matches granted slice.
- req=4'b1010, rr_ptr=0 -> gnt 0010 then 1000 then 0010; owner 1,3,1.
- req=4'b0001, full forced 1 for 3 cycles -> Wr_enable=0 throughout; first cycle full=0 gnt=0001, wr_count increments once.
- FIFO_ARB_BURST_EN, BURST_LEN=4, req=4'b0011 -> gnt 0001 ×4 (busy=1), then 0010 ×4, then 0001; requester 0 dropping req after 2 writes -> one idle cycle then gnt=0010.
- reset_n pulsed low mid-burst (owner=2) -> gnt/Wr_enable 0 immediately; after release with req=4'b1100 first gnt=0100, busy cleared.
- 65540 continuous writes -> wr_count saturates at 16'hFFFF.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between NUM_REQ producers, the arbiter and the FIFO write port.
// slave = arbiter view, master = producer/FIFO/bench view.
interface fifo_wr_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4
);
    localparam int PW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic                          full;
    logic [NUM_REQ-1:0]            gnt;
    logic                          Wr_enable;
    logic [DATA_WIDTH-1:0]         data_in;
    logic [PW-1:0]                 owner;
    logic                          busy;
    logic [15:0]                   wr_count;

    modport slave (
        input  req, req_data, full,
        output gnt, Wr_enable, data_in, owner, busy, wr_count
    );

    modport master (
        output req, req_data, full,
        input  gnt, Wr_enable, data_in, owner, busy, wr_count
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers; grant path is
// combinational. Optional burst lock is enabled by defining FIFO_ARB_BURST_EN.
//
//   state     | meaning
//   ST_IDLE   | round-robin search from rr_ptr over all requesters
//   ST_LOCKED | only the owner is eligible until its burst ends or it drops req
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int BURST_LEN  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    fifo_wr_arbiter_if.slave  bus
);
    localparam int PW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || BURST_LEN < 1 || BURST_LEN > 15) begin : g_param_check
        $error("fifo_wr_arbiter: NUM_REQ must be 2..8 and BURST_LEN 1..15");
    end

    logic [PW-1:0]         rr_ptr;
    logic [PW-1:0]         owner_q;
    logic [15:0]           wr_count_q;
    logic [NUM_REQ-1:0]    elig;
    logic [PW-1:0]         win;
    logic [PW-1:0]         win_next;
    logic [PW-1:0]         cand;
    logic                  found;
    logic                  grant;
    logic [NUM_REQ-1:0]    gnt_c;
    logic [DATA_WIDTH-1:0] data_c;

`ifdef FIFO_ARB_BURST_EN
    typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

    state_t        state;
    logic [3:0]    burst_left;
    logic          busy_q;
    logic [PW-1:0] owner_next;

    always_comb begin
        elig = bus.req;
        if (state == ST_LOCKED) begin
            elig = bus.req & (NUM_REQ'(1) << owner_q);
        end
    end

    assign owner_next = (owner_q == PW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
`else
    assign elig = bus.req;
`endif

    // First eligible requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = PW'((int'(rr_ptr) + i) % NUM_REQ);
            if (!found && elig[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign grant    = found && !bus.full && reset_n;
    assign win_next = (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;

    always_comb begin
        gnt_c  = '0;
        data_c = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant && win == PW'(k)) begin
                gnt_c[k] = 1'b1;
                data_c   = bus.req_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr     <= '0;
            owner_q    <= '0;
            wr_count_q <= '0;
`ifdef FIFO_ARB_BURST_EN
            state      <= ST_IDLE;
            burst_left <= '0;
            busy_q     <= 1'b0;
`endif
        end else begin
            if (grant && wr_count_q != 16'hFFFF) begin
                wr_count_q <= wr_count_q + 16'd1;
            end
`ifdef FIFO_ARB_BURST_EN
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        owner_q <= win;
                        if (BURST_LEN > 1) begin
                            state      <= ST_LOCKED;
                            busy_q     <= 1'b1;
                            burst_left <= 4'(BURST_LEN - 1);
                        end else begin
                            rr_ptr <= win_next;
                        end
                    end
                end
                ST_LOCKED: begin
                    // full stalls the burst without touching the lock or its count.
                    if (!bus.full) begin
                        if (grant) begin
                            if (burst_left == 4'd1) begin
                                state      <= ST_IDLE;
                                busy_q     <= 1'b0;
                                burst_left <= '0;
                                rr_ptr     <= win_next;
                            end else begin
                                burst_left <= burst_left - 4'd1;
                            end
                        end else begin
                            state      <= ST_IDLE;
                            busy_q     <= 1'b0;
                            burst_left <= '0;
                            rr_ptr     <= owner_next;
                        end
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    busy_q     <= 1'b0;
                    burst_left <= '0;
                end
            endcase
`else
            if (grant) begin
                owner_q <= win;
                rr_ptr  <= win_next;
            end
`endif
        end
    end

    assign bus.gnt       = gnt_c;
    assign bus.Wr_enable = |gnt_c;
    assign bus.data_in   = data_c;
    assign bus.owner     = owner_q;
    assign bus.wr_count  = wr_count_q;
`ifdef FIFO_ARB_BURST_EN
    assign bus.busy      = busy_q;
`else
    assign bus.busy      = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (4 requesters, 8-bit data, BURST_LEN 4).
module tb_fifo_wr_arbiter;
    logic clk;
    logic reset_n;
    int   checks;
    int   failures;

    fifo_wr_arbiter_if #(.DATA_WIDTH(8), .NUM_REQ(4)) bus ();

    fifo_wr_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4), .BURST_LEN(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cyc();
        reset_n  = 1'b0;
        bus.req  = 4'b0000;
        bus.full = 1'b0;
        #2;
        reset_n  = 1'b1;
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        bus.req      = 4'b1111;
        bus.full     = 1'b0;
        bus.req_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        #2;
        checks++; if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", bus.gnt); end
        checks++; if (bus.Wr_enable !== 1'b0) begin failures++; $display("FAIL reset_wr_enable got=%b exp=0", bus.Wr_enable); end
        checks++; if (bus.data_in !== 8'h00) begin failures++; $display("FAIL reset_data_in got=%h exp=00", bus.data_in); end
        checks++; if (bus.owner !== 2'd0) begin failures++; $display("FAIL reset_owner got=%0d exp=0", bus.owner); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.wr_count !== 16'd0) begin failures++; $display("FAIL reset_wr_count got=%0d exp=0", bus.wr_count); end
        cyc();
        reset_n = 1'b1;
    endtask

    task automatic test_round_robin();
        logic [3:0] eg;
        logic [7:0] ed;
        int         idx;
        do_reset();
        bus.req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            idx = n % 4;
            eg  = 4'b0001 << idx;
            ed  = 8'hA0 + 8'(idx * 17);
            #4;
            checks++; if (bus.gnt !== eg) begin failures++; $display("FAIL rr_gnt n=%0d got=%b exp=%b", n, bus.gnt, eg); end
            checks++; if (bus.data_in !== ed) begin failures++; $display("FAIL rr_data n=%0d got=%h exp=%h", n, bus.data_in, ed); end
            checks++; if (bus.Wr_enable !== 1'b1) begin failures++; $display("FAIL rr_wr_enable n=%0d got=%b exp=1", n, bus.Wr_enable); end
            cyc();
            checks++; if (bus.owner !== 2'(idx)) begin failures++; $display("FAIL rr_owner n=%0d got=%0d exp=%0d", n, bus.owner, idx); end
        end
        checks++; if (bus.wr_count !== 16'd5) begin failures++; $display("FAIL rr_wr_count got=%0d exp=5", bus.wr_count); end
    endtask

    task automatic test_sparse_pattern();
        logic [3:0] eg [3];
        logic [1:0] eo [3];
        eg[0] = 4'b0010; eg[1] = 4'b1000; eg[2] = 4'b0010;
        eo[0] = 2'd1;    eo[1] = 2'd3;    eo[2] = 2'd1;
        do_reset();
        bus.req = 4'b1010;
        for (int n = 0; n < 3; n++) begin
            #4;
            checks++; if (bus.gnt !== eg[n]) begin failures++; $display("FAIL sparse_gnt n=%0d got=%b exp=%b", n, bus.gnt, eg[n]); end
            cyc();
            checks++; if (bus.owner !== eo[n]) begin failures++; $display("FAIL sparse_owner n=%0d got=%0d exp=%0d", n, bus.owner, eo[n]); end
        end
    endtask

    task automatic test_full_stall();
        do_reset();
        bus.req  = 4'b0001;
        bus.full = 1'b1;
        for (int n = 0; n < 3; n++) begin
            #4;
            checks++; if (bus.Wr_enable !== 1'b0) begin failures++; $display("FAIL full_wr_enable n=%0d got=%b exp=0", n, bus.Wr_enable); end
            checks++; if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL full_gnt n=%0d got=%b exp=0000", n, bus.gnt); end
            cyc();
        end
        checks++; if (bus.wr_count !== 16'd0) begin failures++; $display("FAIL full_count_held got=%0d exp=0", bus.wr_count); end
        bus.full = 1'b0;
        #4;
        checks++; if (bus.gnt !== 4'b0001) begin failures++; $display("FAIL full_release_gnt got=%b exp=0001", bus.gnt); end
        cyc();
        bus.req = 4'b0000;
        checks++; if (bus.wr_count !== 16'd1) begin failures++; $display("FAIL full_release_count got=%0d exp=1", bus.wr_count); end
        cyc();
        checks++; if (bus.wr_count !== 16'd1) begin failures++; $display("FAIL idle_count got=%0d exp=1", bus.wr_count); end

        // full arriving with requests pending keeps the same next winner
        do_reset();
        bus.req = 4'b0011;
        cyc();
        bus.full = 1'b1;
        cyc();
        cyc();
        bus.full = 1'b0;
        #4;
`ifdef FIFO_ARB_BURST_EN
        checks++; if (bus.gnt !== 4'b0001) begin failures++; $display("FAIL full_resume_gnt got=%b exp=0001", bus.gnt); end
`else
        checks++; if (bus.gnt !== 4'b0010) begin failures++; $display("FAIL full_resume_gnt got=%b exp=0010", bus.gnt); end
`endif
        checks++; if (bus.owner !== 2'd0) begin failures++; $display("FAIL full_owner_held got=%0d exp=0", bus.owner); end
        cyc();
        bus.req = 4'b0000;
    endtask

`ifdef FIFO_ARB_BURST_EN
    task automatic test_burst();
        logic [3:0] eg;
        do_reset();
        bus.req = 4'b0011;
        for (int n = 0; n < 10; n++) begin
            eg = (n >= 4 && n < 8) ? 4'b0010 : 4'b0001;
            #4;
            checks++; if (bus.gnt !== eg) begin failures++; $display("FAIL burst_gnt n=%0d got=%b exp=%b", n, bus.gnt, eg); end
            cyc();
            checks++; if (bus.busy !== ((n % 4) != 3)) begin failures++; $display("FAIL burst_busy n=%0d got=%b exp=%b", n, bus.busy, ((n % 4) != 3)); end
        end
        bus.req = 4'b0010;
        #4;
        checks++; if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL burst_bubble got=%b exp=0000", bus.gnt); end
        cyc();
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL burst_drop_busy got=%b exp=0", bus.busy); end
        #4;
        checks++; if (bus.gnt !== 4'b0010) begin failures++; $display("FAIL burst_after_drop got=%b exp=0010", bus.gnt); end
        cyc();
        bus.req = 4'b0000;
    endtask
`endif

    task automatic test_reset_mid_burst();
        do_reset();
        bus.req = 4'b0100;
        #4;
        checks++; if (bus.gnt !== 4'b0100) begin failures++; $display("FAIL mid_first_gnt got=%b exp=0100", bus.gnt); end
        cyc();
        cyc();
        checks++; if (bus.owner !== 2'd2) begin failures++; $display("FAIL mid_owner got=%0d exp=2", bus.owner); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL mid_reset_gnt got=%b exp=0000", bus.gnt); end
        checks++; if (bus.Wr_enable !== 1'b0) begin failures++; $display("FAIL mid_reset_wr_enable got=%b exp=0", bus.Wr_enable); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL mid_reset_busy got=%b exp=0", bus.busy); end
        bus.req = 4'b1100;
        #1;
        reset_n = 1'b1;
        #1;
        checks++; if (bus.gnt !== 4'b0100) begin failures++; $display("FAIL mid_release_gnt got=%b exp=0100", bus.gnt); end
        checks++; if (bus.data_in !== 8'hC2) begin failures++; $display("FAIL mid_release_data got=%h exp=c2", bus.data_in); end
        cyc();
        checks++; if (bus.wr_count !== 16'd1) begin failures++; $display("FAIL mid_release_count got=%0d exp=1", bus.wr_count); end
        bus.req = 4'b0000;
    endtask

    task automatic test_saturation();
        do_reset();
        bus.req = 4'b0001;
        repeat (65534) cyc();
        checks++; if (bus.wr_count !== 16'hFFFE) begin failures++; $display("FAIL sat_pre got=%h exp=fffe", bus.wr_count); end
        repeat (6) cyc();
        checks++; if (bus.wr_count !== 16'hFFFF) begin failures++; $display("FAIL sat_hold got=%h exp=ffff", bus.wr_count); end
        bus.req = 4'b0000;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
`ifdef FIFO_ARB_BURST_EN
        test_burst();
`else
        test_round_robin();
        test_sparse_pattern();
`endif
        test_full_stall();
        test_reset_mid_burst();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
